// File: rtl/shift_serializer_tx_pkg.sv
// Shared types and helpers for the shift serializer transmitter.
package ser_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    // Bit counter width for an N-bit word: $clog2(N+1), which also covers the parity slot.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n + 1 <= 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shift_serializer_tx_if.sv
// Parallel-load handshake and serial output bundle for shift_serializer_tx.
interface shift_serializer_tx_if #(
    parameter int unsigned N = 8
);
    logic [N-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         dir;
    logic         sout;
    logic         sout_valid;
    logic         sout_last;

    modport master (
        output din, din_valid, dir,
        input  din_ready, sout, sout_valid, sout_last
    );

    modport slave (
        input  din, din_valid, dir,
        output din_ready, sout, sout_valid, sout_last
    );
endinterface

// File: rtl/shift_serializer_tx_bit_counter.sv
// Frame bit counter: cleared on load, advanced on enable, flags the final bit slot.
module ser_bit_counter #(
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned CW        = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          last
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign last = (count == CW'(FRAME_LEN - 1));

endmodule

// File: rtl/shift_serializer_tx.sv
// Parallel-in/serial-out transmitter with per-word direction select.
// Optional even-parity trailer bit when SHIFT_SERIALIZER_PARITY_EN is defined.
module shift_serializer_tx
    import ser_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 shift_en,
    output logic                 busy,
    shift_serializer_tx_if.slave bus
);

`ifdef SHIFT_SERIALIZER_PARITY_EN
    localparam int unsigned FRAME_LEN = N + 1;
`else
    localparam int unsigned FRAME_LEN = N;
`endif
    localparam int unsigned CW = cnt_width(N);

    state_t         state, state_nx;
    logic [N-1:0]   sreg;
    logic           dir_q;
    logic           load, adv;
    logic [CW-1:0]  count;
    logic           last;
    logic           data_bit;
    logic           par_bit;

    ser_bit_counter #(
        .FRAME_LEN (FRAME_LEN),
        .CW        (CW)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .enable (adv),
        .count  (count),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            sreg  <= '0;
            dir_q <= DIR_MSB_FIRST;
        end else begin
            state <= state_nx;
            if (load) begin
                sreg  <= bus.din;
                dir_q <= bus.dir;
            end else if (adv) begin
                if (dir_q == DIR_MSB_FIRST) sreg <= {sreg[N-2:0], 1'b0};
                else                        sreg <= {1'b0, sreg[N-1:1]};
            end
        end
    end

`ifdef SHIFT_SERIALIZER_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (!reset)    par_q <= 1'b0;
        else if (load) par_q <= ^bus.din;
    end

    assign par_bit = par_q;
`else
    assign par_bit = 1'b0;
`endif

    assign data_bit = (dir_q == DIR_MSB_FIRST) ? sreg[N-1] : sreg[0];

    always_comb begin
        state_nx       = state;
        load           = 1'b0;
        adv            = 1'b0;
        busy           = 1'b0;
        bus.din_ready  = 1'b0;
        bus.sout       = 1'b0;
        bus.sout_valid = 1'b0;
        bus.sout_last  = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.din_ready = 1'b1;
                if (bus.din_valid) begin
                    load     = 1'b1;
                    state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy           = 1'b1;
                bus.sout_valid = 1'b1;
                bus.sout_last  = last;
                // Slots past the N data bits can only be the parity trailer.
                bus.sout       = (count < CW'(N)) ? data_bit : par_bit;
                if (shift_en) begin
                    if (last) begin
                        // Final bit frees the slot: accept the next word with no gap cycle.
                        bus.din_ready = 1'b1;
                        if (bus.din_valid) load = 1'b1;
                        else               state_nx = ST_IDLE;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule
